// File: rtl/operand_issue_stage_if.sv
// Decode/writeback/execute handshake bundle for operand_issue_stage.
// The stage uses the slave modport; the driving environment uses master.
interface operand_issue_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [4:0]  in_rd;
  logic        in_writes_rd;
  logic        in_is_load;
  logic [31:0] data_rs;
  logic [31:0] data_rt;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_rs_val;
  logic [31:0] out_rt_val;
  logic [4:0]  out_rd;
  logic        out_writes_rd;
  logic        out_is_load;
  logic        err_underflow;

  modport master (
    output in_valid, in_rs, in_rt, in_rd, in_writes_rd, in_is_load,
    output data_rs, data_rt, wb_en, wb_rd, wb_data, flush, out_ready,
    input  in_ready, out_valid, out_rs_val, out_rt_val, out_rd,
    input  out_writes_rd, out_is_load, err_underflow
  );

  modport slave (
    input  in_valid, in_rs, in_rt, in_rd, in_writes_rd, in_is_load,
    input  data_rs, data_rt, wb_en, wb_rd, wb_data, flush, out_ready,
    output in_ready, out_valid, out_rs_val, out_rt_val, out_rd,
    output out_writes_rd, out_is_load, err_underflow
  );
endinterface

// File: rtl/operand_issue_stage.sv
// Issue stage with per-register RAW scoreboard; 1-cycle latency, in_ready drops on hazard/flush/backpressure.
// Define OPERAND_BYPASS_EN to forward same-cycle writeback data into the operands.
module operand_issue_stage (
  input  logic                 clk,
  input  logic                 rst,
  operand_issue_stage_if.slave io
);
  logic [15:0][1:0] pend_q, pend_d;
  logic             out_valid_q, out_valid_d;
  logic [31:0]      out_rs_val_q, out_rs_val_d;
  logic [31:0]      out_rt_val_q, out_rt_val_d;
  logic [4:0]       out_rd_q, out_rd_d;
  logic             out_writes_rd_q, out_writes_rd_d;
  logic             out_is_load_q, out_is_load_d;
  logic             err_underflow_q, err_underflow_d;

  logic [3:0]  rs_idx, rt_idx, rd_idx, wb_idx, fl_idx;
  logic        byp_rs, byp_rt;
  logic        haz_rs, haz_rt, haz_rd;
  logic        in_ready, accept, underflow;
  logic [31:0] rs_val, rt_val;
  logic        inc, dec_wb, dec_fl;
  logic [2:0]  sum, net;
  logic [1:0]  sub;
  logic        unused_bits;

  assign rs_idx = io.in_rs[3:0];
  assign rt_idx = io.in_rt[3:0];
  assign rd_idx = io.in_rd[3:0];
  assign wb_idx = io.wb_rd[3:0];
  assign fl_idx = out_rd_q[3:0];
  assign unused_bits = ^{io.in_rs[4], io.in_rt[4], io.wb_rd[4], io.wb_data};

`ifdef OPERAND_BYPASS_EN
  assign byp_rs = io.wb_en && (wb_idx == rs_idx);
  assign byp_rt = io.wb_en && (wb_idx == rt_idx);
`else
  assign byp_rs = 1'b0;
  assign byp_rt = 1'b0;
`endif

  // A single outstanding write is only safe when its writeback is being forwarded right now.
  assign haz_rs = (rs_idx != 4'd0) &&
                  ((pend_q[rs_idx] >= 2'd2) || ((pend_q[rs_idx] == 2'd1) && !byp_rs));
  assign haz_rt = (rt_idx != 4'd0) &&
                  ((pend_q[rt_idx] >= 2'd2) || ((pend_q[rt_idx] == 2'd1) && !byp_rt));
  assign haz_rd = io.in_writes_rd && (rd_idx != 4'd0) && (pend_q[rd_idx] == 2'd3);

  assign in_ready = (!out_valid_q || io.out_ready) && !haz_rs && !haz_rt && !haz_rd && !io.flush;
  assign accept   = io.in_valid && in_ready;

  assign rs_val = (rs_idx == 4'd0) ? 32'd0 : (byp_rs ? io.wb_data : io.data_rs);
  assign rt_val = (rt_idx == 4'd0) ? 32'd0 : (byp_rt ? io.wb_data : io.data_rt);

  always_comb begin
    pend_d    = pend_q;
    pend_d[0] = 2'd0;
    underflow = 1'b0;
    inc       = 1'b0;
    dec_wb    = 1'b0;
    dec_fl    = 1'b0;
    sum       = 3'd0;
    sub       = 2'd0;
    net       = 3'd0;
    for (int i = 1; i < 16; i++) begin
      inc    = accept && io.in_writes_rd && (rd_idx == 4'(i));
      dec_wb = io.wb_en && (wb_idx == 4'(i));
      dec_fl = io.flush && out_valid_q && out_writes_rd_q && (fl_idx == 4'(i));
      sum    = {1'b0, pend_q[i]} + {2'b00, inc};
      sub    = {1'b0, dec_wb} + {1'b0, dec_fl};
      net    = sum - {1'b0, sub};
      if (sum < {1'b0, sub}) begin
        pend_d[i] = 2'd0;
      end else if (net > 3'd3) begin
        pend_d[i] = 2'd3;
      end else begin
        pend_d[i] = net[1:0];
      end
      if (dec_wb && (pend_q[i] == 2'd0)) begin
        underflow = 1'b1;
      end
    end
  end

  always_comb begin
    out_valid_d     = out_valid_q;
    out_rs_val_d    = out_rs_val_q;
    out_rt_val_d    = out_rt_val_q;
    out_rd_d        = out_rd_q;
    out_writes_rd_d = out_writes_rd_q;
    out_is_load_d   = out_is_load_q;
    err_underflow_d = err_underflow_q | underflow;
    if (accept) begin
      out_valid_d     = 1'b1;
      out_rs_val_d    = rs_val;
      out_rt_val_d    = rt_val;
      out_rd_d        = io.in_rd;
      out_writes_rd_d = io.in_writes_rd;
      out_is_load_d   = io.in_is_load;
    end else if (io.flush || io.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q          <= '0;
      out_valid_q     <= 1'b0;
      out_rs_val_q    <= 32'd0;
      out_rt_val_q    <= 32'd0;
      out_rd_q        <= 5'd0;
      out_writes_rd_q <= 1'b0;
      out_is_load_q   <= 1'b0;
      err_underflow_q <= 1'b0;
    end else begin
      pend_q          <= pend_d;
      out_valid_q     <= out_valid_d;
      out_rs_val_q    <= out_rs_val_d;
      out_rt_val_q    <= out_rt_val_d;
      out_rd_q        <= out_rd_d;
      out_writes_rd_q <= out_writes_rd_d;
      out_is_load_q   <= out_is_load_d;
      err_underflow_q <= err_underflow_d;
    end
  end

  assign io.in_ready      = in_ready;
  assign io.out_valid     = out_valid_q;
  assign io.out_rs_val    = out_rs_val_q;
  assign io.out_rt_val    = out_rt_val_q;
  assign io.out_rd        = out_rd_q;
  assign io.out_writes_rd = out_writes_rd_q;
  assign io.out_is_load   = out_is_load_q;
  assign io.err_underflow = err_underflow_q;
endmodule

// File: tb/tb_operand_issue_stage.sv
// Directed bench for operand_issue_stage: stimulus pushes expected issues, a monitor pops on each handshake.
module tb_operand_issue_stage;
  typedef struct packed {
    logic [31:0] rs;
    logic [31:0] rt;
    logic [4:0]  rd;
    logic        w;
    logic        ld;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  operand_issue_stage_if io ();
  operand_issue_stage dut (.clk(clk), .rst(rst), .io(io));

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] rs, input logic [31:0] rt, input logic [4:0] rd,
                          input logic w, input logic ld);
    exp_t e;
    e.rs = rs; e.rt = rt; e.rd = rd; e.w = w; e.ld = ld;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic w, input logic ld, input logic [31:0] drs, input logic [31:0] drt);
    io.in_valid     = 1'b1;
    io.in_rs        = rs;
    io.in_rt        = rt;
    io.in_rd        = rd;
    io.in_writes_rd = w;
    io.in_is_load   = ld;
    io.data_rs      = drs;
    io.data_rt      = drt;
  endtask

  task automatic idle();
    io.in_valid = 1'b0;
  endtask

  // Present an instruction, wait (bounded) for in_ready, record the expected result, then clock it in.
  task automatic issue(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic w, input logic ld, input logic [31:0] drs, input logic [31:0] drt,
                       input logic [31:0] ers, input logic [31:0] ert, output int waited);
    bit ok;
    drive(rs, rt, rd, w, ld, drs, drt);
    waited = 0;
    ok = 1'b0;
    while (!ok && waited <= 20) begin
      @(negedge clk);
      if (io.in_ready) ok = 1'b1;
      else begin
        waited++;
        @(posedge clk);
        #1;
      end
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL issue_timeout: in_ready stayed 0, expected 1 within 20 cycles");
      idle();
      step();
    end else begin
      push_exp(ers, ert, rd, w, ld);
      step();
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && io.out_valid && io.out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_issue: got rs=0x%0h, expected no transfer", io.out_rs_val);
        end else begin
          e = exp_q.pop_front();
          check("out_rs_val", io.out_rs_val, e.rs);
          check("out_rt_val", io.out_rt_val, e.rt);
          check("out_rd", 32'(io.out_rd), 32'(e.rd));
          check("out_writes_rd", 32'(io.out_writes_rd), 32'(e.w));
          check("out_is_load", 32'(io.out_is_load), 32'(e.ld));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation still running, expected to finish");
    $fatal(1);
  end

  initial begin : stimulus
    int waited;
    rst = 1'b1;
    io.in_valid = 1'b0; io.in_rs = '0; io.in_rt = '0; io.in_rd = '0;
    io.in_writes_rd = 1'b0; io.in_is_load = 1'b0; io.data_rs = '0; io.data_rt = '0;
    io.wb_en = 1'b0; io.wb_rd = '0; io.wb_data = '0; io.flush = 1'b0; io.out_ready = 1'b1;
    repeat (2) step();
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_out_valid", 32'(io.out_valid), 0);
    check("rst_out_rs_val", io.out_rs_val, 0);
    check("rst_out_rt_val", io.out_rt_val, 0);
    check("rst_out_rd", 32'(io.out_rd), 0);
    check("rst_out_flags", 32'({io.out_writes_rd, io.out_is_load}), 0);
    check("rst_err", 32'(io.err_underflow), 0);
    check("rst_in_ready", 32'(io.in_ready), 1);
    step();

    // Plain issue, one-cycle latency
    drive(5'd2, 5'd3, 5'd0, 1'b0, 1'b0, 32'h11, 32'h22);
    @(negedge clk);
    check("basic_ready", 32'(io.in_ready), 1);
    push_exp(32'h11, 32'h22, 5'd0, 1'b0, 1'b0);
    step();
    idle();
    @(negedge clk);
    check("basic_latency", 32'(io.out_valid), 1);
    step();

    // RAW on r5; r0 source reads zero regardless of bank data
    issue(5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 32'hDEAD, 32'hBEEF, 32'h0, 32'h0, waited);
    drive(5'd5, 5'd1, 5'd0, 1'b0, 1'b0, 32'h5555, 32'h1111);
    repeat (2) begin
      @(negedge clk);
      check("raw_stall", 32'(io.in_ready), 0);
      step();
    end
    io.wb_en = 1'b1; io.wb_rd = 5'd5; io.wb_data = 32'hABCD;
`ifdef OPERAND_BYPASS_EN
    @(negedge clk);
    check("raw_bypass_ready", 32'(io.in_ready), 1);
    push_exp(32'hABCD, 32'h1111, 5'd0, 1'b0, 1'b0);
    step();
    io.wb_en = 1'b0;
`else
    @(negedge clk);
    check("raw_wb_cycle_ready", 32'(io.in_ready), 0);
    step();
    io.wb_en = 1'b0;
    io.data_rs = 32'hABCD;
    @(negedge clk);
    check("raw_next_ready", 32'(io.in_ready), 1);
    push_exp(32'hABCD, 32'h1111, 5'd0, 1'b0, 1'b0);
    step();
`endif
    idle();
    step();

    // Backpressure: output held three cycles, released when out_ready returns
    io.out_ready = 1'b0;
    issue(5'd6, 5'd7, 5'd8, 1'b0, 1'b1, 32'h66, 32'h77, 32'h66, 32'h77, waited);
    drive(5'd2, 5'd3, 5'd0, 1'b0, 1'b0, 32'h1, 32'h2);
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready", 32'(io.in_ready), 0);
      check("bp_out_valid", 32'(io.out_valid), 1);
      check("bp_rs_stable", io.out_rs_val, 32'h66);
      check("bp_rt_stable", io.out_rt_val, 32'h77);
      step();
    end
    io.out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", 32'(io.in_ready), 1);
    push_exp(32'h1, 32'h2, 5'd0, 1'b0, 1'b0);
    step();
    idle();
    step();

    // Underflow: writeback to r7 with nothing pending, sticky until reset
    @(negedge clk);
    check("err_before", 32'(io.err_underflow), 0);
    step();
    io.wb_en = 1'b1; io.wb_rd = 5'd7; io.wb_data = 32'h7777;
    step();
    io.wb_en = 1'b0;
    @(negedge clk);
    check("err_set", 32'(io.err_underflow), 1);
    repeat (4) step();
    @(negedge clk);
    check("err_sticky", 32'(io.err_underflow), 1);
    step();

    // Flush a held writer of r4; its pending count must drop
    io.out_ready = 1'b0;
    issue(5'd0, 5'd0, 5'd4, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, waited);
    void'(exp_q.pop_back());
    idle();
    io.flush = 1'b1;
    step();
    io.flush = 1'b0;
    @(negedge clk);
    check("flush_clears_valid", 32'(io.out_valid), 0);
    step();
    drive(5'd4, 5'd0, 5'd0, 1'b0, 1'b0, 32'h4444, 32'h9);
    @(negedge clk);
    check("flush_pend_cleared", 32'(io.in_ready), 1);
    push_exp(32'h4444, 32'h0, 5'd0, 1'b0, 1'b0);
    step();
    idle();
    io.out_ready = 1'b1;
    step();

    // Flush alongside a valid instruction blocks acceptance
    drive(5'd2, 5'd3, 5'd0, 1'b0, 1'b0, 32'h1, 32'h2);
    io.flush = 1'b1;
    @(negedge clk);
    check("flush_blocks_ready", 32'(io.in_ready), 0);
    step();
    io.flush = 1'b0;
    idle();
    @(negedge clk);
    check("flush_no_issue", 32'(io.out_valid), 0);
    step();

    // Three writers of r9 back to back, fourth stalls until a writeback
    for (int k = 0; k < 3; k++) begin
      issue(5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, waited);
      check("r9_writer_no_stall", 32'(waited), 0);
    end
    drive(5'd0, 5'd0, 5'd9, 1'b1, 1'b1, 32'h0, 32'h0);
    repeat (2) begin
      @(negedge clk);
      check("dest_full_stall", 32'(io.in_ready), 0);
      step();
    end
    io.wb_en = 1'b1; io.wb_rd = 5'd9; io.wb_data = 32'h9999;
    @(negedge clk);
    check("dest_wb_cycle", 32'(io.in_ready), 0);
    step();
    io.wb_en = 1'b0;
    @(negedge clk);
    check("dest_release", 32'(io.in_ready), 1);
    push_exp(32'h0, 32'h0, 5'd9, 1'b1, 1'b1);
    step();
    idle();
    step();

    // Reset mid-transfer drops the held instruction, the flag and the scoreboard
    io.out_ready = 1'b0;
    issue(5'd1, 5'd0, 5'd0, 1'b0, 1'b0, 32'h10, 32'h0, 32'h10, 32'h0, waited);
    void'(exp_q.pop_back());
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", 32'(io.out_valid), 0);
    check("midrst_err", 32'(io.err_underflow), 0);
    step();
    io.out_ready = 1'b1;
    issue(5'd9, 5'd9, 5'd9, 1'b1, 1'b0, 32'h99, 32'h98, 32'h99, 32'h98, waited);
    check("midrst_pend_cleared", 32'(waited), 0);
    idle();
    repeat (2) step();
    check("queue_drained", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/operand_issue_stage.md
# operand_issue_stage

Decode-to-execute issue stage that sits directly downstream of `registers_bank`. It latches the decoded instruction together with the `data_rs`/`data_rt` values read from the bank. It tracks in-flight register writes with a per-register scoreboard and stalls issue on read-after-write hazards. When the bypass feature is compiled in, it forwards same-cycle writeback data that the bank has not yet stored.

## Interface
- Parameters: none.
- `clk` in 1: single clock, all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: decode presents an instruction.
- `in_ready` out 1: stage accepts the instruction this cycle.
- `in_rs`, `in_rt`, `in_rd` in 5 each: register indices. Bits [3:0] select r0..r15. Bit 4 is ignored.
- `in_writes_rd` in 1: the instruction writes `in_rd`.
- `in_is_load` in 1: the instruction is a load (passed through).
- `data_rs`, `data_rt` in 32 each: bank read data for `in_rs`/`in_rt`, valid in the same cycle.
- `wb_en`, `wb_rd` (5), `wb_data` (32) in: writeback port. These are the same signals that drive the bank's `en`/`rd`/`data`.
- `flush` in 1: discard the held instruction.
- `out_valid` out 1; `out_ready` in 1: handshake to execute.
- `out_rs_val`, `out_rt_val` out 32 each: resolved operands.
- `out_rd` out 5; `out_writes_rd` out 1; `out_is_load` out 1: registered pass-through fields.
- `err_underflow` out 1: sticky flag. Set when a writeback targets a register with pending count 0.

## Operation
- r0 reads as 0 and is never pending. Writes to r0 are ignored by the scoreboard.
- Scoreboard: one 2-bit counter `pend[i]` per register r1..r15.
  - Increments on accept when `in_writes_rd` is set and `in_rd[3:0]` != 0.
  - Decrements on `wb_en` when `wb_rd[3:0]` != 0.
  - Increment and decrement on the same register in the same cycle leave the count unchanged.
  - A decrement at count 0 leaves the count at 0 and sets `err_underflow`.
- Source hazard on rs (same rule for rt), for a non-zero index:
  - Hazard if `pend` ≥ 2.
  - Hazard if `pend` == 1 and the bypass is not usable this cycle.
- Destination hazard: `pend[in_rd]` == 3 and `in_writes_rd` is set.
- `in_ready` = (!`out_valid` | `out_ready`) & no source hazard & no destination hazard & !`flush`.
- Accept = `in_valid` & `in_ready`. On accept:
  - Load the output register.
  - Operand value is 0 for r0.
  - Otherwise the operand is `wb_data` when bypass is active and `wb_en` matches the index.
  - Otherwise the operand is `data_rs`/`data_rt`.
- Output register holds its contents while `out_valid` & !`out_ready`.
- `flush` clears `out_valid` next cycle. If the held instruction had `out_writes_rd` set, its `pend[out_rd]` decrements in that same cycle, net of any other increment or decrement.

## Timing
- Reset values:
  - `out_valid`, `out_writes_rd`, `out_is_load`, `err_underflow` = 0.
  - All 32-bit and 5-bit outputs = 0.
  - All `pend` = 0.
- Latency: accept in cycle N, so `out_valid`=1 with operands in cycle N+1.
- Throughput: 1 per cycle when there are no hazards and `out_ready`=1.
- `in_ready` is combinational from scoreboard state, `out_valid`/`out_ready`, `wb_*` and `flush`.
- Writeback in cycle N is visible in the bank from cycle N+1. Without bypass, a dependent instruction is accepted at N+1 at the earliest.
- `rst` in the middle of a transfer discards the held instruction and the scoreboard. `rst` takes priority over `flush`, accept and `wb_en`.
- `flush` in the same cycle as `in_valid`: no accept.

## Configuration
- `OPERAND_BYPASS_EN` defined:
  - A source with `pend` == 1 and a matching `wb_en` in the same cycle is not a hazard.
  - The operand takes `wb_data`.
- `OPERAND_BYPASS_EN` undefined:
  - A source with `pend` ≠ 0 is always a hazard.
  - Operands always come from `data_rs`/`data_rt`, or 0 for r0.

## Test plan
- Reset, then issue `rs`=2, `rt`=3 with bank data 0x11/0x22, no writes pending → cycle N+1: `out_valid`=1, `out_rs_val`=0x11, `out_rt_val`=0x22.
- Issue a writer of r5, then a reader of r5 → `in_ready`=0 until `wb_en` with `wb_rd`=5, `wb_data`=0xABCD.
  - With bypass: accepted in the same cycle, `out_rs_val`=0xABCD.
  - Without bypass: accepted one cycle later using bank data.
- `out_ready`=0 for 3 cycles with `out_valid`=1 → outputs stable, `in_ready`=0; released on the cycle `out_ready`=1.
- `wb_en` with `wb_rd`=7 while `pend[7]`=0 → `err_underflow`=1 and stays set until `rst`.
- Hold a writer of r4 (`pend[4]`=1), assert `flush` → next cycle `out_valid`=0 and `pend[4]`=0. A reader of r4 is accepted immediately after.
- Three outstanding writers of r9 (`pend`=3), fourth writer presented → `in_ready`=0 until a `wb_rd`=9 writeback.
